// File: rtl/alu_iter.sv
// alu_iter: handshaked EX-stage ALU running the base op set at XLEN width.
// Define ALU_ITER_MULDIV_EN to add the one-bit-per-cycle RV M-extension datapath.
module alu_iter #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      func,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  // state | meaning
  // IDLE  | waiting for a request; the only state with in_ready high
  // CALC  | one multiply/divide iteration per edge, counter counts down
  // FIX   | apply signs, pick product half / quotient / remainder
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_ITER_MULDIV_EN
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] base_res;
  logic [SHW-1:0]  shamt;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign shamt     = rs2[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (func[3:0])
      4'b0000: base_res = rs1 + rs2;
      4'b1000: base_res = rs1 - rs2;
      4'b0001: base_res = rs1 << shamt;
      4'b0010: base_res[0] = $signed(rs1) < $signed(rs2);
      4'b0011: base_res[0] = rs1 < rs2;
      4'b0100: base_res = rs1 ^ rs2;
      4'b0101: base_res = rs1 >> shamt;
      4'b1101: base_res = $signed(rs1) >>> shamt;
      4'b0110: base_res = rs1 | rs2;
      4'b0111: base_res = rs1 & rs2;
      4'b1110: base_res = rs2;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_ITER_MULDIV_EN
  localparam int CNTW = SHW + 1;

  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2:0]        op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              s1, s2, a_neg, b_neg, div_zero, div_ovf, div_ge;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem, fix_res;
  logic [XLEN:0]     mul_sum, div_cand;
  logic [2*XLEN-1:0] mul_step, div_step, prod;

  // Operand signedness and special cases are decided from the raw request.
  always_comb begin
    s1       = func[2] ? ~func[0] : (func[1:0] == 2'b01 || func[1:0] == 2'b10);
    s2       = func[2] ? ~func[0] : (func[1:0] == 2'b01);
    a_neg    = s1 & rs1[XLEN-1];
    b_neg    = s2 & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    div_zero = func[2] && (rs2 == '0);
    div_ovf  = func[2] && !func[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  end

  // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_cand = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = div_cand >= {1'b0, dvs_q};
    div_step = div_ge ? {div_cand[XLEN-1:0] - dvs_q, acc_q[XLEN-2:0], 1'b1}
                      : {div_cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod     = qneg_q ? -acc_q : acc_q;
    quo      = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         fix_res = prod[XLEN-1:0];
      3'b100, 3'b101: fix_res = quo;
      3'b110, 3'b111: fix_res = rem;
      default:        fix_res = prod[2*XLEN-1:XLEN];
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef ALU_ITER_MULDIV_EN
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    op_d   = op_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            if (!func[4]) begin
              result_d = base_res;
            end
`ifdef ALU_ITER_MULDIV_EN
            else if (div_zero) begin
              result_d = func[1] ? rs1 : '1;
            end else if (div_ovf) begin
              result_d = func[1] ? '0 : rs1;
            end else begin
              state_d     = S_CALC;
              out_valid_d = 1'b0;
              cnt_d       = CNTW'(XLEN);
              op_d        = func[2:0];
              qneg_d      = a_neg ^ b_neg;
              rneg_d      = func[2] & a_neg;
              dvs_d       = func[2] ? b_mag : a_mag;
              acc_d       = {{XLEN{1'b0}}, (func[2] ? a_mag : b_mag)};
            end
`else
            else begin
              result_d = '0;
            end
`endif
          end
        end
`ifdef ALU_ITER_MULDIV_EN
        S_CALC: begin
          acc_d = op_q[2] ? div_step : mul_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d    = fix_res;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
      cnt_q  <= '0;
      acc_q  <= '0;
      dvs_q  <= '0;
      op_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_ITER_MULDIV_EN
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      op_q   <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked successor to the core's combinational ALU. Executes the existing 4-bit ALU operation set at configurable width, plus the RV M-extension (multiply/divide/remainder) via an iterative one-bit-per-cycle datapath. Sits in the EX stage between the decode/issue logic and writeback; a valid/ready pair on each side lets EX stall on multi-cycle operations.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- func  in  5  func[4]=0: base op in func[3:0]; func[4]=1: M op in func[2:0] (RV funct3)
- rs1, rs2  in  XLEN  operands, sampled on acceptance edge only
- flush  in  1  abandon current operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result

## Operation
- Acceptance: edge where in_valid && in_ready. func/rs1/rs2 latched; later changes ignored.
- Base ops (func[4]=0): 0000 add, 1000 sub, 0001 sll, 0010 slt (signed), 0011 sltu, 0100 xor, 0101 srl, 1101 sra (arithmetic, sign-filling), 0110 or, 0111 and, 1110 pass rs2, 1001/1010/1011/1100/1111 → 0. Shifts use rs2[SHW-1:0]. Add/sub wrap modulo 2^XLEN.
- M ops (func[4]=1, func[2:0]): 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU. Division truncates toward zero; remainder takes dividend's sign.
- Multiply: operands converted to magnitudes per signedness, XLEN shift-add iterations into 2·XLEN product, sign applied in FIX.
- Divide: magnitudes, XLEN restoring iterations, quotient/remainder signs applied in FIX.
- Special cases resolved at acceptance, no iteration: divisor 0 → DIV/DIVU all ones, REM/REMU = rs1; signed overflow (rs1 = 1 followed by zeros, rs2 = all ones) → DIV = rs1, REM = 0.
- FSM: IDLE → (accept base/special) DONE; IDLE → (accept M) CALC, counter = XLEN; CALC: one iteration per edge, counter−1; counter reaches 0 → FIX; FIX → DONE; DONE → (out_ready) IDLE.
- flush: any state → IDLE next edge, out_valid low, result retains value; a request offered with flush high is not accepted.
- Reset (rst_n low at edge): state IDLE, counter 0, result 0, out_valid 0, in_ready 1; mid-operation reset discards work.

## Timing
- in_ready = (state == IDLE); no combinational path from out_ready or in_valid to in_ready.
- Base op / special case: out_valid high after acceptance edge E0 (latency 1).
- M op: CALC spans edges E0+1..E0+XLEN, FIX at E0+XLEN+1; out_valid high after edge E0+XLEN+1 (XLEN+1 edges).
- result and out_valid registered; result stable while out_valid && !out_ready.
- out_valid drops on edge where out_ready sampled high in DONE; next acceptance no earlier than following edge (max throughput 1 base op per 2 cycles).

## Configuration
- ALU_ITER_MULDIV_EN defined: M ops, CALC/FIX states, iteration datapath compiled in as above.
- Undefined: no multiply/divide hardware; any func[4]=1 request completes like a base op with latency 1 and result 0.

## Test plan
- Reset: hold rst_n low 2 edges with in_valid high → out_valid 0, in_ready 1, result 0; nothing accepted.
- Base ops, XLEN=32: add 5+7 → 12; sub 0−1 → 0xFFFFFFFF; sra 0x80000000 by 4 → 0xF8000000; srl same → 0x08000000; slt 0xFFFFFFFF<1 → 1, sltu → 0; each out_valid exactly 1 edge after acceptance.
- Multiply: rs1=0xFFFFFFFF, rs2=2 → MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHU 0x00000001, MULHSU 0xFFFFFFFF; out_valid exactly 33 edges after acceptance.
- Divide: DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF; DIV 7/0 → 0xFFFFFFFF, REMU 7/0 → 7 in 1 edge; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0 in 1 edge.
- Handshake: out_ready low 5 cycles in DONE → result stable, in_ready low; flush asserted 10 edges into a MUL → IDLE next edge, no out_valid, next request accepted normally.
- Macro undefined: MULHU 3×4 → result 0, out_valid 1 edge after acceptance.
